// File: rtl/waveform_buffer_reader.sv
// waveform_buffer_reader: pops an event header, walks the waveform buffer from start to stop
// (with wrap) and streams the samples with sof/eof tags, flagging stored end-of-event mismatches.
module waveform_buffer_reader #(
  parameter int P_DATA_WIDTH = 28,
  parameter int P_ADR_WIDTH  = 15,
  parameter int P_HDR_WIDTH  = 87,
  parameter int P_RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data_out,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data_out,
  output logic [P_HDR_WIDTH-1:0]  out_hdr,
  output logic [P_DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sof,
  output logic                    out_eof,
  output logic                    busy,
  output logic                    eoe_err
);
  localparam int D  = P_RD_LATENCY + 2;
  localparam int IW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_CAP   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]              r_state;
  logic [P_HDR_WIDTH-1:0]  r_hdr;
  logic [P_ADR_WIDTH-1:0]  r_rd_ptr;
  logic [P_ADR_WIDTH:0]    r_remaining;
  logic                    r_first;
  logic                    r_eoe_err;
  logic [P_RD_LATENCY-1:0] r_vld;
  logic [P_RD_LATENCY-1:0] r_tf;
  logic [P_RD_LATENCY-1:0] r_tl;
  logic [P_DATA_WIDTH+1:0] r_mem [D];
  logic [IW-1:0]           r_wr_idx;
  logic [IW-1:0]           r_rd_idx;
  logic [CW-1:0]           r_count;

  logic [P_ADR_WIDTH-1:0]  w_start;
  logic [P_ADR_WIDTH-1:0]  w_stop;
  logic [CW-1:0]           w_inflight;
  logic                    w_credit;
  logic                    w_issue;
  logic                    w_last_issue;
  logic                    w_wr;
  logic                    w_pop;
  logic                    w_eoe_bad;
  logic [P_DATA_WIDTH+1:0] w_rd_word;
  logic [2:0]              w_next;

  assign w_start      = hdr_data_out[P_ADR_WIDTH-1:0];
  assign w_stop       = hdr_data_out[2*P_ADR_WIDTH-1:P_ADR_WIDTH];
  assign hdr_rdreq    = r_state == S_POP;
  assign busy         = r_state != S_IDLE;
  assign wvb_rd_addr  = r_rd_ptr;
  assign out_hdr      = r_hdr;
  assign eoe_err      = r_eoe_err;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < P_RD_LATENCY; i++) w_inflight = w_inflight + CW'(r_vld[i]);
  end

  // Reserving FIFO space for every read in flight keeps the output FIFO from overflowing.
  assign w_credit     = ({1'b0, w_inflight} + {1'b0, r_count}) < (CW+1)'(D);
  assign w_issue      = (r_state == S_READ) && w_credit;
  assign w_last_issue = w_issue && (r_remaining == (P_ADR_WIDTH+1)'(1));
  assign w_wr         = r_vld[P_RD_LATENCY-1];
  assign w_rd_word    = r_mem[r_rd_idx];
  assign out_valid    = r_count != '0;
  assign out_data     = w_rd_word[P_DATA_WIDTH+1:2];
  assign out_sof      = out_valid && w_rd_word[1];
  assign out_eof      = out_valid && w_rd_word[0];
  assign w_pop        = out_valid && out_ready;
  assign w_eoe_bad    = w_wr && (wvb_data_out[0] != r_tl[P_RD_LATENCY-1]);

  always_comb begin
    w_next = r_state == S_IDLE  ? ((en && !hdr_empty) ? S_POP : S_IDLE) :
             r_state == S_POP   ? S_CAP :
             r_state == S_CAP   ? S_READ :
             r_state == S_READ  ? (w_last_issue ? S_DRAIN : S_READ) :
             r_state == S_DRAIN ? ((w_pop && out_eof) ? S_IDLE : S_DRAIN) : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_hdr       <= '0;
      r_rd_ptr    <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_eoe_err   <= 1'b0;
      r_vld       <= '0;
      r_tf        <= '0;
      r_tl        <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CAP) begin
        r_hdr       <= hdr_data_out;
        r_rd_ptr    <= w_start;
        r_remaining <= {1'b0, w_stop - w_start} + (P_ADR_WIDTH+1)'(1);
        r_first     <= 1'b1;
      end else if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + P_ADR_WIDTH'(1);
        r_remaining <= r_remaining - (P_ADR_WIDTH+1)'(1);
        r_first     <= 1'b0;
      end
      r_vld <= (r_vld << 1) | P_RD_LATENCY'(w_issue);
      r_tf  <= (r_tf << 1) | P_RD_LATENCY'(w_issue && r_first);
      r_tl  <= (r_tl << 1) | P_RD_LATENCY'(w_last_issue);
      if (w_eoe_bad) r_eoe_err <= 1'b1;
    end
  end

  // First-word-fall-through output FIFO carrying {sample, sof, eof}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_idx] <= {wvb_data_out, r_tf[P_RD_LATENCY-1], r_tl[P_RD_LATENCY-1]};
        r_wr_idx        <= (r_wr_idx == IW'(D-1)) ? '0 : r_wr_idx + IW'(1);
      end
      if (w_pop) r_rd_idx <= (r_rd_idx == IW'(D-1)) ? '0 : r_rd_idx + IW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_waveform_buffer_reader.sv
// tb_waveform_buffer_reader: directed scenarios against header FIFO and waveform buffer models,
// with a negedge monitor collecting accepted beats.
module tb_waveform_buffer_reader;
  localparam int L = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        hdr_empty;
  logic [86:0] hdr_data_out = '0;
  logic        hdr_rdreq;
  logic [14:0] wvb_rd_addr;
  logic [27:0] wvb_data_out;
  logic [86:0] out_hdr;
  logic [27:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sof;
  logic        out_eof;
  logic        busy;
  logic        eoe_err;

  waveform_buffer_reader #(.P_DATA_WIDTH(28), .P_ADR_WIDTH(15), .P_HDR_WIDTH(87), .P_RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .en(en), .hdr_empty(hdr_empty), .hdr_data_out(hdr_data_out),
    .hdr_rdreq(hdr_rdreq), .wvb_rd_addr(wvb_rd_addr), .wvb_data_out(wvb_data_out),
    .out_hdr(out_hdr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .eoe_err(eoe_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  logic [27:0] wmem [0:32767];
  logic [27:0] rd_q0 = '0;
  logic [27:0] rd_q1 = '0;
  assign wvb_data_out = rd_q1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_q0 <= wmem[wvb_rd_addr];
    rd_q1 <= rd_q0;
  end

  logic [86:0] hdrs [0:31];
  int   pushed = 0;
  int   popped = 0;
  logic force_empty = 1'b0;
  assign hdr_empty = force_empty || (pushed == popped);
  always @(posedge clk) if (hdr_rdreq) begin
    hdr_data_out <= hdrs[popped[4:0]];
    popped       <= popped + 1;
  end

  logic [27:0] bd [0:511];
  logic        bs [0:511];
  logic        be [0:511];
  int          bc [0:511];
  int          nb = 0;
  int          nreq = 0;
  int          req_cyc = 0;
  int          unstable = 0;
  logic        stall = 1'b0;
  logic [27:0] pd = '0;
  logic        ps = 1'b0;
  logic        pe = 1'b0;
  always @(negedge clk) begin
    if (hdr_rdreq) begin
      nreq    <= nreq + 1;
      req_cyc <= cyc;
    end
    if (out_valid && out_ready) begin
      bd[nb] <= out_data;
      bs[nb] <= out_sof;
      be[nb] <= out_eof;
      bc[nb] <= cyc;
      nb     <= nb + 1;
    end
    if (stall && rst && (out_data !== pd || out_sof !== ps || out_eof !== pe)) unstable <= unstable + 1;
    stall <= out_valid && !out_ready;
    pd    <= out_data;
    ps    <= out_sof;
    pe    <= out_eof;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [27:0] samp(input logic [14:0] start, input int k, input int n, input int errpos);
    logic [14:0] a;
    a = start + 15'(k);
    return {a, 12'h5A3, ((k == n - 1) != (k == errpos))};
  endfunction

  task automatic push_event(input logic [14:0] start, input int n, input int errpos, output logic [86:0] h);
    logic [14:0] stop;
    for (int k = 0; k < n; k++) wmem[15'(start + 15'(k))] = samp(start, k, n, errpos);
    stop = start + 15'(n - 1);
    h = {57'h0ABC_DEF0_1234_5678 + 57'(pushed), stop, start};
    hdrs[pushed[4:0]] = h;
    pushed++;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int c = 0;
    while (nb < target && c < budget) begin
      step(1);
      c++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(3);
    nvec += 9;
    if (hdr_rdreq !== 1'b0) begin nerr++; $display("FAIL reset hdr_rdreq: got %b want 0", hdr_rdreq); end
    if (wvb_rd_addr !== 15'h0) begin nerr++; $display("FAIL reset wvb_rd_addr: got %h want 0", wvb_rd_addr); end
    if (out_hdr !== 87'h0) begin nerr++; $display("FAIL reset out_hdr: got %h want 0", out_hdr); end
    if (out_data !== 28'h0) begin nerr++; $display("FAIL reset out_data: got %h want 0", out_data); end
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    if (out_sof !== 1'b0) begin nerr++; $display("FAIL reset out_sof: got %b want 0", out_sof); end
    if (out_eof !== 1'b0) begin nerr++; $display("FAIL reset out_eof: got %b want 0", out_eof); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL reset busy: got %b want 0", busy); end
    if (eoe_err !== 1'b0) begin nerr++; $display("FAIL reset eoe_err: got %b want 0", eoe_err); end
    rst = 1'b1;
    step(2);
  endtask

  task automatic test_single;
    logic [86:0] h;
    int n0 = nb;
    int r0 = nreq;
    out_ready = 1'b1;
    en = 1'b1;
    push_event(15'h0010, 4, -1, h);
    wait_beats(n0 + 4, 60);
    nvec++;
    if (nb != n0 + 4) begin nerr++; $display("FAIL single beat count: got %0d want 4", nb - n0); end
    for (int k = 0; k < 4; k++) begin
      nvec += 3;
      if (bd[n0+k] !== samp(15'h0010, k, 4, -1)) begin nerr++; $display("FAIL single data[%0d]: got %h want %h", k, bd[n0+k], samp(15'h0010, k, 4, -1)); end
      if (bs[n0+k] !== (k == 0)) begin nerr++; $display("FAIL single sof[%0d]: got %b want %b", k, bs[n0+k], k == 0); end
      if (be[n0+k] !== (k == 3)) begin nerr++; $display("FAIL single eof[%0d]: got %b want %b", k, be[n0+k], k == 3); end
    end
    step(3);
    nvec += 6;
    if (bc[n0] - req_cyc != L + 3) begin nerr++; $display("FAIL single first latency: got %0d want %0d", bc[n0] - req_cyc, L + 3); end
    if (bc[n0+3] - bc[n0] != 3) begin nerr++; $display("FAIL single beat spacing: got %0d want 3", bc[n0+3] - bc[n0]); end
    if (nreq - r0 != 1) begin nerr++; $display("FAIL single rdreq pulses: got %0d want 1", nreq - r0); end
    if (eoe_err !== 1'b0) begin nerr++; $display("FAIL single eoe_err: got %b want 0", eoe_err); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL single busy after: got %b want 0", busy); end
    if (out_hdr !== h) begin nerr++; $display("FAIL single out_hdr: got %h want %h", out_hdr, h); end
  endtask

  task automatic test_wrap;
    logic [86:0] h;
    int n0 = nb;
    push_event(15'h7FFE, 4, -1, h);
    wait_beats(n0 + 4, 60);
    step(3);
    nvec++;
    if (nb != n0 + 4) begin nerr++; $display("FAIL wrap beat count: got %0d want 4", nb - n0); end
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (bd[n0+k] !== samp(15'h7FFE, k, 4, -1)) begin nerr++; $display("FAIL wrap data[%0d]: got %h want %h", k, bd[n0+k], samp(15'h7FFE, k, 4, -1)); end
    end
  endtask

  task automatic test_backpressure;
    logic [86:0] h;
    int n0 = nb;
    int u0 = unstable;
    out_ready = 1'b0;
    push_event(15'h0100, 16, -1, h);
    for (int i = 0; i < 14; i++) begin
      out_ready = (i % 2 == 0);
      step(1);
    end
    out_ready = 1'b0;
    step(20);
    out_ready = 1'b1;
    wait_beats(n0 + 16, 100);
    step(3);
    nvec += 3;
    if (nb != n0 + 16) begin nerr++; $display("FAIL bp beat count: got %0d want 16", nb - n0); end
    if (unstable != u0) begin nerr++; $display("FAIL bp stall stability: got %0d changes want 0", unstable - u0); end
    if (eoe_err !== 1'b0) begin nerr++; $display("FAIL bp eoe_err: got %b want 0", eoe_err); end
    for (int k = 0; k < 16; k++) begin
      nvec += 2;
      if (bd[n0+k] !== samp(15'h0100, k, 16, -1)) begin nerr++; $display("FAIL bp data[%0d]: got %h want %h", k, bd[n0+k], samp(15'h0100, k, 16, -1)); end
      if (be[n0+k] !== (k == 15)) begin nerr++; $display("FAIL bp eof[%0d]: got %b want %b", k, be[n0+k], k == 15); end
    end
  endtask

  task automatic test_gating;
    logic [86:0] ha;
    logic [86:0] hb;
    int n0 = nb;
    int r0 = nreq;
    int c = 0;
    en = 1'b0;
    push_event(15'h0200, 8, -1, ha);
    step(20);
    nvec += 2;
    if (nreq != r0) begin nerr++; $display("FAIL gate en=0 rdreq: got %0d pulses want 0", nreq - r0); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL gate en=0 busy: got %b want 0", busy); end
    force_empty = 1'b1;
    en = 1'b1;
    step(20);
    nvec += 2;
    if (nreq != r0) begin nerr++; $display("FAIL gate empty rdreq: got %0d pulses want 0", nreq - r0); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL gate empty busy: got %b want 0", busy); end
    force_empty = 1'b0;
    while (!busy && c < 20) begin
      step(1);
      c++;
    end
    en = 1'b0;
    push_event(15'h0300, 3, -1, hb);
    wait_beats(n0 + 8, 60);
    step(20);
    nvec += 4;
    if (nb != n0 + 8) begin nerr++; $display("FAIL gate mid-event beats: got %0d want 8", nb - n0); end
    if (nreq != r0 + 1) begin nerr++; $display("FAIL gate mid-event rdreq: got %0d pulses want 1", nreq - r0); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL gate mid-event busy: got %b want 0", busy); end
    if (be[n0+7] !== 1'b1) begin nerr++; $display("FAIL gate event A eof: got %b want 1", be[n0+7]); end
    en = 1'b1;
    wait_beats(n0 + 11, 60);
    step(3);
    nvec += 3;
    if (nb != n0 + 11) begin nerr++; $display("FAIL gate event B beats: got %0d want 3", nb - n0 - 8); end
    if (bd[n0+8] !== samp(15'h0300, 0, 3, -1)) begin nerr++; $display("FAIL gate event B data: got %h want %h", bd[n0+8], samp(15'h0300, 0, 3, -1)); end
    if (bs[n0+8] !== 1'b1) begin nerr++; $display("FAIL gate event B sof: got %b want 1", bs[n0+8]); end
  endtask

  task automatic test_eoe_err;
    logic [86:0] h;
    int n0 = nb;
    push_event(15'h0400, 5, 2, h);
    wait_beats(n0 + 5, 60);
    step(3);
    nvec += 2;
    if (nb != n0 + 5) begin nerr++; $display("FAIL eoe beat count: got %0d want 5", nb - n0); end
    if (eoe_err !== 1'b1) begin nerr++; $display("FAIL eoe flag: got %b want 1", eoe_err); end
    for (int k = 0; k < 5; k++) begin
      nvec++;
      if (bd[n0+k] !== samp(15'h0400, k, 5, 2)) begin nerr++; $display("FAIL eoe data[%0d]: got %h want %h", k, bd[n0+k], samp(15'h0400, k, 5, 2)); end
    end
    push_event(15'h0500, 2, -1, h);
    wait_beats(n0 + 7, 60);
    step(3);
    nvec += 2;
    if (nb != n0 + 7) begin nerr++; $display("FAIL eoe clean beats: got %0d want 2", nb - n0 - 5); end
    if (eoe_err !== 1'b1) begin nerr++; $display("FAIL eoe sticky: got %b want 1", eoe_err); end
  endtask

  task automatic test_reset_mid;
    logic [86:0] h;
    int n0;
    int c = 0;
    push_event(15'h0600, 16, -1, h);
    while (!busy && c < 20) begin
      step(1);
      c++;
    end
    step(4);
    rst = 1'b0;
    #1;
    nvec += 9;
    if (hdr_rdreq !== 1'b0) begin nerr++; $display("FAIL midrst hdr_rdreq: got %b want 0", hdr_rdreq); end
    if (wvb_rd_addr !== 15'h0) begin nerr++; $display("FAIL midrst wvb_rd_addr: got %h want 0", wvb_rd_addr); end
    if (out_hdr !== 87'h0) begin nerr++; $display("FAIL midrst out_hdr: got %h want 0", out_hdr); end
    if (out_data !== 28'h0) begin nerr++; $display("FAIL midrst out_data: got %h want 0", out_data); end
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
    if (out_sof !== 1'b0) begin nerr++; $display("FAIL midrst out_sof: got %b want 0", out_sof); end
    if (out_eof !== 1'b0) begin nerr++; $display("FAIL midrst out_eof: got %b want 0", out_eof); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL midrst busy: got %b want 0", busy); end
    if (eoe_err !== 1'b0) begin nerr++; $display("FAIL midrst eoe_err: got %b want 0", eoe_err); end
    step(2);
    rst = 1'b1;
    step(2);
    n0 = nb;
    push_event(15'h0700, 3, -1, h);
    wait_beats(n0 + 3, 60);
    step(3);
    nvec += 4;
    if (nb != n0 + 3) begin nerr++; $display("FAIL postrst beats: got %0d want 3", nb - n0); end
    if (bs[n0] !== 1'b1) begin nerr++; $display("FAIL postrst sof: got %b want 1", bs[n0]); end
    if (bd[n0] !== samp(15'h0700, 0, 3, -1)) begin nerr++; $display("FAIL postrst data: got %h want %h", bd[n0], samp(15'h0700, 0, 3, -1)); end
    if (out_hdr !== h) begin nerr++; $display("FAIL postrst out_hdr: got %h want %h", out_hdr, h); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_backpressure;
    test_gating;
    test_eoe_err;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/waveform_buffer_reader.md
# waveform_buffer_reader

Readout engine for the waveform buffer storage block. It pops one header from the header FIFO and extracts the event's start/stop addresses. It then walks the waveform buffer read port from start to stop, including wrap-around, and presents the samples as a valid/ready stream to the downstream formatter, with the header held alongside. It checks the end-of-event bit stored in sample bit 0 and flags mismatches.

## Interface
- P_DATA_WIDTH, 28, waveform sample width (bit 0 = stored eoe flag)
- P_ADR_WIDTH, 15, waveform buffer address width
- P_HDR_WIDTH, 87, header width; [P_ADR_WIDTH-1:0] = start addr, [2*P_ADR_WIDTH-1:P_ADR_WIDTH] = stop addr, rest opaque
- P_RD_LATENCY, 2, waveform buffer read latency (addr to data), 1..4
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- en  in  1  permit starting new events; a low level never aborts an event in progress
- hdr_empty  in  1  header FIFO empty
- hdr_data_out  in  P_HDR_WIDTH  header FIFO read data, valid 1 cycle after hdr_rdreq
- hdr_rdreq  out  1  header FIFO pop, 1-cycle pulse
- wvb_rd_addr  out  P_ADR_WIDTH  waveform buffer read address
- wvb_data_out  in  P_DATA_WIDTH  waveform buffer read data, P_RD_LATENCY after address
- out_hdr  out  P_HDR_WIDTH  captured header, stable while busy
- out_data  out  P_DATA_WIDTH  sample
- out_valid  out  1  sample valid
- out_ready  in  1  downstream accept; beat transfers when out_valid && out_ready
- out_sof  out  1  first sample of event (qualified by out_valid)
- out_eof  out  1  last sample of event (qualified by out_valid)
- busy  out  1  event in progress (HDR_POP through final beat accepted)
- eoe_err  out  1  sticky: eoe bit mismatch seen

## Operation
- States: IDLE, HDR_POP, HDR_CAP, READ, DRAIN.
- IDLE: if en && !hdr_empty → HDR_POP.
- HDR_POP: hdr_rdreq=1 for exactly this cycle → HDR_CAP.
- HDR_CAP: register hdr_data_out into out_hdr. rd_ptr = start. remaining = ((stop − start) mod 2^P_ADR_WIDTH) + 1, computed in P_ADR_WIDTH+1 bits. Range is 1..2^P_ADR_WIDTH; stop == start−1 means a full buffer → READ.
- READ: issue one address per cycle while credit available. wvb_rd_addr = rd_ptr; rd_ptr increments modulo 2^P_ADR_WIDTH (wraps max→0). remaining decrements. Last issue → DRAIN.
- Credit: in-flight reads + output FIFO occupancy < P_RD_LATENCY+2. Output FIFO depth is P_RD_LATENCY+2, first-word-fall-through, so it never overflows under any out_ready pattern.
- Valid pipeline: a P_RD_LATENCY-deep shift register tags each issued read with first/last flags. Returned data is written to the output FIFO with those tags.
- DRAIN: wait for the last beat to be accepted → IDLE. busy drops the cycle after that transfer.
- eoe check: sample bit 0 must be 1 on the last sample and 0 on all others. Any violation sets eoe_err. The data is forwarded unmodified.
- out_sof/out_eof are both set on a 1-sample event.
- Reset: state IDLE. Clears the FIFO, pipeline, rd_ptr and remaining. Outputs: hdr_rdreq=0, wvb_rd_addr=0, out_hdr=0, out_data=0, out_valid=0, out_sof=0, out_eof=0, busy=0, eoe_err=0. Reset mid-event discards the event; the popped header is not re-read.

## Timing
- en && !hdr_empty sampled in IDLE at cycle T: hdr_rdreq=1 at T+1, header captured at T+2 edge, first address at T+3.
- First sample out_valid at T+3+P_RD_LATENCY+1 (one FIFO write cycle).
- With out_ready held high, one beat per cycle, no bubbles; N-sample event's last beat at T+3+P_RD_LATENCY+N.
- Back-to-back events: after the final beat is accepted, at least 3 idle cycles pass before the next event's first address (IDLE, HDR_POP, HDR_CAP).
- out_data/out_sof/out_eof hold stable while out_valid && !out_ready.
- busy asserts at T+1 (HDR_POP).

## Test plan
- Single event start=0x0010, stop=0x0013, eoe on last, out_ready=1 → 4 beats of addrs 0x10..0x13 in order, sof on beat 0, eof on beat 3, eoe_err=0, single hdr_rdreq pulse.
- Wrap: start=0x7FFE, stop=0x0001 → wvb_rd_addr 0x7FFE,0x7FFF,0x0000,0x0001; 4 beats.
- Backpressure: 16-sample event, out_ready toggling 1010… then held low 20 cycles → all 16 samples delivered exactly once, in order, data stable while stalled.
- Gating: hdr_empty=1 or en=0 → hdr_rdreq never asserts, busy=0. en dropped mid-event → current event completes, no new pop.
- eoe error: stored eoe=1 on sample 2 of 5 → stream unchanged, eoe_err=1 and stays 1 until rst=0.
- Reset mid-event: rst=0 during READ → all outputs at reset values. Next header after release is read normally with correct sof.
